// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller:
//   NUM_IRQ_DEF   default number of external request lines
//   intc_state_t  issue FSM states (IDLE, ASSERT, SERVICE)
//   VEC_W()       width of the vector index: clog2(n), never less than 1
// -----------------------------------------------------------------------------
package intc_pkg;

   localparam int NUM_IRQ_DEF = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      SERVICE = 2'd2
   } intc_state_t;

   function automatic int VEC_W(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// -----------------------------------------------------------------------------
// irq_sync_edge
// One external interrupt line: 2-FF synchroniser followed by a rising-edge
// detector.
// Ports:
//   Clk   in  clock
//   Rst   in  asynchronous active-low reset
//   Arm   in  1 = edge detection enabled; 0 = arming, prev follows the input
//   Async in  raw asynchronous request line
//   Rise  out one-cycle pulse on a synchronised rising edge
// -----------------------------------------------------------------------------
module irq_sync_edge (
   input  logic Clk,
   input  logic Rst,
   input  logic Arm,
   input  logic Async,
   output logic Rise
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
      end else begin
         sync1_reg <= Async;
         sync2_reg <= sync1_reg;
         // While arming, prev is preloaded with the value sync2 is about to
         // take, so a line held high through reset is already "seen" by the
         // time detection is enabled and never produces an edge.
         prev_reg  <= Arm ? sync2_reg : sync1_reg;
      end
   end

   assign Rise = Arm & sync2_reg & ~prev_reg;

endmodule

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
// Synchronises NUM_IRQ asynchronous request lines, latches their rising edges
// as pending, applies a software mask and fixed lowest-index-first priority,
// and issues one interrupt at a time to the processor.
// Ports:
//   Clk      in  clock
//   Rst      in  asynchronous active-low reset
//   IrqIn    in  [NUM_IRQ]  asynchronous requests, rising-edge sensitive
//   MaskWe   in  mask write enable
//   MaskIn   in  [NUM_IRQ]  new mask value (1 = line disabled)
//   IntRet   in  one-cycle pulse: processor retired its RTI
//   Int      out interrupt request, high HOLD_CYCLES cycles per issue
//   IntVec   out [VW]  index of the line being serviced
//   Busy     out high from issue until IntRet
//   Pending  out [NUM_IRQ] pending register (status)
// -----------------------------------------------------------------------------
module interrupt_controller
   import intc_pkg::*;
#(
   parameter int                   NUM_IRQ     = NUM_IRQ_DEF,
   parameter int                   HOLD_CYCLES = 2,
   parameter logic [NUM_IRQ-1:0]   MASK_RST    = '0,
   localparam int                  VW          = VEC_W(NUM_IRQ)
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic [NUM_IRQ-1:0] IrqIn,
   input  logic               MaskWe,
   input  logic [NUM_IRQ-1:0] MaskIn,
   input  logic               IntRet,
   output logic               Int,
   output logic [VW-1:0]      IntVec,
   output logic               Busy,
   output logic [NUM_IRQ-1:0] Pending
);

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   intc_state_t        state_reg;
   logic               int_reg;
   logic [VW-1:0]      vec_reg;
   logic               busy_reg;
   logic [3:0]         hold_cnt_reg;
   logic [NUM_IRQ-1:0] pending_reg;
   logic [NUM_IRQ-1:0] pending_next;
   logic [NUM_IRQ-1:0] mask_reg;
   logic [1:0]         arm_cnt_reg;
   logic               arm;

   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] eligible;
   logic [VW-1:0]      winner;
   logic               issue;
   logic [NUM_IRQ-1:0] clr;

   // Edge detection stays off for the first two cycles after reset release.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         arm_cnt_reg <= 2'd2;
      end else if (arm_cnt_reg != 2'd0) begin
         arm_cnt_reg <= arm_cnt_reg - 2'd1;
      end
   end

   assign arm = (arm_cnt_reg == 2'd0);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
         irq_sync_edge u_sync (
            .Clk   (Clk),
            .Rst   (Rst),
            .Arm   (arm),
            .Async (IrqIn[gi]),
            .Rise  (rise[gi])
         );
      end
   endgenerate

   // Selection uses the registered mask, so a mask written this cycle only
   // affects selection from the next cycle on.
   assign eligible = pending_reg & ~mask_reg;
   assign issue    = (state_reg == IDLE) && (eligible != '0);

   // Fixed priority: scan downwards so the lowest set index is written last.
   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = VW'(i);
         end
      end
   end

   assign clr = issue ? (NUM_IRQ'(1) << winner) : '0;

   // A new edge in the same cycle as the clear keeps the line pending.
   assign pending_next = (pending_reg & ~clr) | rise;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_reg    <= IDLE;
         int_reg      <= 1'b0;
         vec_reg      <= '0;
         busy_reg     <= 1'b0;
         hold_cnt_reg <= 4'd0;
         pending_reg  <= '0;
         mask_reg     <= MASK_RST;
      end else begin
         pending_reg <= pending_next;
         if (MaskWe) begin
            mask_reg <= MaskIn;
         end
         case (state_reg)
            IDLE: begin
               if (issue) begin
                  state_reg    <= ASSERT;
                  int_reg      <= 1'b1;
                  vec_reg      <= winner;
                  busy_reg     <= 1'b1;
                  hold_cnt_reg <= HOLD_LOAD;
               end
            end
            ASSERT: begin
               if (hold_cnt_reg == 4'd0) begin
                  state_reg <= SERVICE;
                  int_reg   <= 1'b0;
               end else begin
                  hold_cnt_reg <= hold_cnt_reg - 4'd1;
               end
            end
            SERVICE: begin
               if (IntRet) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               int_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign Int     = int_reg;
   assign IntVec  = vec_reg;
   assign Busy    = busy_reg;
   assign Pending = pending_reg;

endmodule
